// File: rtl/arashi_cache_if.sv
// arashi_cache_if: thread-side write bus plus memory-side drain outputs of
// arashi_cache.
//
// Handshake: thread i raises w_ena[i] with its word on slice i of w_data and
// holds both until the cycle in which w_ack[i] is high. The word is taken at
// the clock edge that closes that cycle. w_data slice i must not change while
// w_ena[i]=1 and unacked. On the memory side there is no back-pressure. Each
// cache_ready pulse announces one word, and that word appears on cache2mem in
// the following cycle.
//
// Signals:
//   w_ena       thread -> cache  per-thread write request
//   w_data      thread -> cache  per-thread word, slice i = [(i+1)*DW-1 : i*DW]
//   w_ack       cache  -> thread one-hot grant, combinational
//   drain_en    ctrl   -> cache  allow the FIFO to drain
//   cache_ready cache  -> mem    one-cycle strobe per word
//   cache2mem   cache  -> mem    word, one cycle after its strobe
//   count       cache  -> ctrl   FIFO occupancy 0..DEPTH
//   full        cache  -> ctrl   count == DEPTH
interface arashi_cache_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 3
);
  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;

  logic [THREAD_NUM-1:0]            w_ena;
  logic [DATA_WIDTH*THREAD_NUM-1:0] w_data;
  logic [THREAD_NUM-1:0]            w_ack;
  logic                             drain_en;
  logic                             cache_ready;
  logic [DATA_WIDTH-1:0]            cache2mem;
  logic [DEPTH_WIDTH:0]             count;
  logic                             full;

  modport master (
    output w_ena, w_data, drain_en,
    input  w_ack, cache_ready, cache2mem, count, full
  );

  modport slave (
    input  w_ena, w_data, drain_en,
    output w_ack, cache_ready, cache2mem, count, full
  );
endinterface

// File: rtl/arashi_cache.sv
// arashi_cache: upstream write collector for arashi_mem.
//
// A round-robin arbiter admits at most one thread word per cycle into a
// DEPTH-entry FIFO. The FIFO drains one word per cycle while drain_en=1.
// Each popped word produces a registered one-cycle cache_ready strobe. The
// word itself follows on cache2mem one cycle later. cache2mem holds its value
// until the next word replaces it.
//
// Ports:
//   clk   input  clock, all logic on posedge
//   rstn  input  asynchronous active-low reset
//   bus   arashi_cache_if.slave, carrying w_ena/w_data/w_ack, drain_en,
//         cache_ready/cache2mem, count and full
module arashi_cache #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 3
) (
  input logic           clk,
  input logic           rstn,
  arashi_cache_if.slave bus
);
  localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;
  localparam int DEPTH      = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]        count_q, count_d;
  logic [THREAD_NUM_WIDTH-1:0] rr_ptr_q, rr_ptr_d;   // first thread searched
  logic                        ready_q, ready_d;
  logic [DATA_WIDTH-1:0]       stage_q, stage_d;     // popped word awaiting output
  logic [DATA_WIDTH-1:0]       c2m_q, c2m_d;

  logic                        full;
  logic                        grant_vld;
  logic [THREAD_NUM_WIDTH-1:0] grant_idx;
  logic [THREAD_NUM_WIDTH-1:0] cand;
  logic                        push;
  logic                        pop;
  logic [THREAD_NUM-1:0]       ack;
  logic [DATA_WIDTH-1:0]       push_data;

  // Full is taken from the current count only. A pop in the same cycle does
  // not open a slot for a push.
  assign full = (count_q == FULL_CNT);

  // Round-robin search beginning at rr_ptr_q. The index wraps on its own
  // because THREAD_NUM is a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < THREAD_NUM; k++) begin
      cand = rr_ptr_q + THREAD_NUM_WIDTH'(k);
      if (!grant_vld && bus.w_ena[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // rstn gates the grant so that w_ack stays low throughout reset.
  assign push      = grant_vld && !full && rstn;
  assign pop       = bus.drain_en && (count_q != '0);
  assign push_data = bus.w_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    ack            = '0;
    ack[grant_idx] = push;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rr_ptr_d = push ? (grant_idx + THREAD_NUM_WIDTH'(1)) : rr_ptr_q;
    ready_d  = pop;
    stage_d  = pop ? mem_q[rd_ptr_q] : stage_q;
    // The word follows its strobe by one cycle and is then held.
    c2m_d    = ready_q ? stage_q : c2m_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      ready_q  <= 1'b0;
      stage_q  <= '0;
      c2m_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      ready_q  <= ready_d;
      stage_q  <= stage_d;
      c2m_q    <= c2m_d;
    end
  end

  // The storage array needs no reset. Reset clears count, so stale entries
  // can never be read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign bus.w_ack       = ack;
  assign bus.cache_ready = ready_q;
  assign bus.cache2mem   = c2m_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
endmodule

// File: tb/tb_arashi_cache.sv
// Bench for arashi_cache: a cycle table for the single-write and arbitration
// cases, plus hand-written multi-cycle sequences. Inputs change on the falling
// edge and outputs are sampled 1 ns later. A scoreboard queue holds the
// expected memory word order.
module tb_arashi_cache;
  localparam int DW  = 32;
  localparam int TW  = 2;
  localparam int TN  = 4;
  localparam int DPW = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  arashi_cache_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW), .DEPTH_WIDTH(DPW)) bus();

  arashi_cache #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW), .DEPTH_WIDTH(DPW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: after each cache_ready pulse, the next cycle's cache2mem must
  // equal the oldest expected word.
  logic mon_prev;
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        mon_prev = 1'b0;
      end else begin
        if (mon_prev) begin
          if (exp_q.size() == 0) chk("unexpected word", bus.cache2mem, 64'hDEAD);
          else                   chk("cache2mem order", bus.cache2mem, exp_q.pop_front());
        end
        mon_prev = bus.cache_ready;
      end
    end
  end

  // Protocol check: a pending (unacked) request must hold its data.
  logic [TN-1:0]    pend_q;
  logic [TN*DW-1:0] held_q;
  initial begin
    pend_q = '0;
    held_q = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < TN; i++) begin
        if (pend_q[i] && bus.w_ena[i]) chk("w_data stable", bus.w_data[i*DW +: DW], held_q[i*DW +: DW]);
      end
      #3;
      pend_q = rstn ? (bus.w_ena & ~bus.w_ack) : '0;
      held_q = bus.w_data;
    end
  end

  typedef struct {
    logic [TN-1:0]    w_ena;
    logic [TN*DW-1:0] wd;
    logic             drain;
    logic [TN-1:0]    ack;
    logic             rdy;
    logic [DW-1:0]    c2m;
    logic [DPW:0]     cnt;
    logic             full;
  } vec_t;

  function automatic vec_t mkv(logic [TN-1:0] e, logic [TN*DW-1:0] wd, logic dr,
                               logic [TN-1:0] a, logic r, logic [DW-1:0] c,
                               logic [DPW:0] n, logic f);
    vec_t v;
    v.w_ena = e; v.wd = wd; v.drain = dr; v.ack = a;
    v.rdy = r; v.c2m = c; v.cnt = n; v.full = f;
    return v;
  endfunction

  function automatic logic [DW-1:0] word(int t, int r);
    return 32'hC0DE_0000 | DW'(r * 256 + t);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    bus.w_ena    = '0;
    bus.w_data   = '0;
    bus.drain_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Thread t pushes 'n' words starting at 'base', one per cycle, each acked.
  task automatic fill(input int t, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.w_ena            = '0;
      bus.w_ena[t]         = 1'b1;
      bus.w_data[t*DW +: DW] = base + DW'(k);
      #1;
      chk("fill ack", bus.w_ack, 64'(1) << t);
      exp_q.push_back(base + DW'(k));
    end
  endtask

  localparam logic [TN*DW-1:0] WD1 = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};
  localparam logic [TN*DW-1:0] WD6 = {32'h33, 32'h0, 32'h11, 32'h0};

  vec_t vecs[11];
  int   rounds[TN];
  int   mc;
  logic exp_rdy;
  logic pop_m;
  int   pulses;

  initial begin
    bus.w_ena    = '0;
    bus.w_data   = '0;
    bus.drain_en = 1'b0;

    // Single write from thread 2, then a two-thread round-robin pick.
    vecs[0]  = mkv(4'b0000, '0,  1, 4'b0000, 0, 32'h0,         0, 0);
    vecs[1]  = mkv(4'b0100, WD1, 1, 4'b0100, 0, 32'h0,         0, 0);
    vecs[2]  = mkv(4'b0000, WD1, 1, 4'b0000, 0, 32'h0,         1, 0);
    vecs[3]  = mkv(4'b0000, WD1, 1, 4'b0000, 1, 32'h0,         0, 0);
    vecs[4]  = mkv(4'b0000, WD1, 1, 4'b0000, 0, 32'hA5A5_0002, 0, 0);
    vecs[5]  = mkv(4'b0000, WD1, 1, 4'b0000, 0, 32'hA5A5_0002, 0, 0);
    vecs[6]  = mkv(4'b1010, WD6, 1, 4'b1000, 0, 32'hA5A5_0002, 0, 0);
    vecs[7]  = mkv(4'b0010, WD6, 1, 4'b0010, 0, 32'hA5A5_0002, 1, 0);
    vecs[8]  = mkv(4'b0000, WD6, 1, 4'b0000, 1, 32'hA5A5_0002, 1, 0);
    vecs[9]  = mkv(4'b0000, WD6, 1, 4'b0000, 1, 32'h33,        0, 0);
    vecs[10] = mkv(4'b0000, WD6, 1, 4'b0000, 0, 32'h11,        0, 0);

    do_reset();
    exp_q.push_back(32'hA5A5_0002);
    exp_q.push_back(32'h33);
    exp_q.push_back(32'h11);
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      bus.w_ena    = vecs[v].w_ena;
      bus.w_data   = vecs[v].wd;
      bus.drain_en = vecs[v].drain;
      #1;
      chk($sformatf("vec%0d w_ack", v),       bus.w_ack,       vecs[v].ack);
      chk($sformatf("vec%0d cache_ready", v), bus.cache_ready, vecs[v].rdy);
      chk($sformatf("vec%0d cache2mem", v),   bus.cache2mem,   vecs[v].c2m);
      chk($sformatf("vec%0d count", v),       bus.count,       vecs[v].cnt);
      chk($sformatf("vec%0d full", v),        bus.full,        vecs[v].full);
    end
    @(negedge clk);
    chk("table words drained", exp_q.size(), 0);

    // Round-robin fairness: all threads request and each makes two words.
    do_reset();
    bus.drain_en = 1'b1;
    for (int i = 0; i < TN; i++) rounds[i] = 0;
    for (int g = 0; g < 8; g++) exp_q.push_back(word(g % TN, g / TN));
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      for (int i = 0; i < TN; i++) begin
        bus.w_ena[i]           = (rounds[i] < 2);
        bus.w_data[i*DW +: DW] = word(i, rounds[i]);
      end
      #1;
      chk("rr grant", bus.w_ack, 64'(1) << (g % TN));
      rounds[g % TN]++;
    end
    @(negedge clk);
    bus.w_ena = '0;
    repeat (6) @(negedge clk);
    #1;
    chk("rr count empty", bus.count, 0);
    chk("rr words drained", exp_q.size(), 0);

    // Full boundary: eight words fill, the ninth waits until a slot opens.
    do_reset();
    fill(0, 8, 32'd1);
    @(negedge clk);
    bus.w_data[DW-1:0] = 32'd9;
    #1;
    chk("full count", bus.count, 8);
    chk("full flag", bus.full, 1);
    chk("full no ack", bus.w_ack, 0);
    @(negedge clk);
    #1;
    chk("full still no ack", bus.w_ack, 0);
    exp_q.push_back(32'd9);
    @(negedge clk);
    bus.drain_en = 1'b1;
    #1;
    chk("pop-only cycle ack", bus.w_ack, 0);
    chk("pop-only cycle count", bus.count, 8);
    @(negedge clk);
    #1;
    chk("word 9 ack", bus.w_ack, 1);
    chk("word 9 count", bus.count, 7);
    @(negedge clk);
    bus.w_ena = '0;
    repeat (12) @(negedge clk);
    #1;
    chk("full drain count", bus.count, 0);
    chk("full drain flag", bus.full, 0);
    chk("full words drained", exp_q.size(), 0);

    // Simultaneous push and pop starting from full, thread 1 requesting.
    do_reset();
    fill(0, 8, 32'h21);
    @(negedge clk);
    bus.w_ena              = 4'b0010;
    bus.w_data[1*DW +: DW] = 32'h31;
    bus.drain_en           = 1'b1;
    exp_q.push_back(32'h31);
    exp_q.push_back(32'h32);
    #1;
    chk("pp first ack", bus.w_ack, 0);
    chk("pp first count", bus.count, 8);
    @(negedge clk);
    #1;
    chk("pp second ack", bus.w_ack, 4'b0010);
    chk("pp second count", bus.count, 7);
    @(negedge clk);
    bus.w_data[1*DW +: DW] = 32'h32;
    #1;
    chk("pp third ack", bus.w_ack, 4'b0010);
    chk("pp third count", bus.count, 7);
    @(negedge clk);
    bus.w_ena = '0;
    #1;
    chk("pp steady count", bus.count, 7);
    repeat (10) @(negedge clk);
    #1;
    chk("pp drain count", bus.count, 0);
    chk("pp words drained", exp_q.size(), 0);

    // Reset while draining with five words still buffered.
    do_reset();
    fill(2, 7, 32'h51);
    @(negedge clk);
    bus.w_ena    = '0;
    bus.drain_en = 1'b1;
    #1;
    chk("pre-reset count", bus.count, 7);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("draining count", bus.count, 5);
    chk("draining ready", bus.cache_ready, 1);
    chk("draining cache2mem", bus.cache2mem, 32'h51);
    #2;
    rstn                   = 1'b0;
    bus.w_ena              = 4'b0100;
    bus.w_data[2*DW +: DW] = 32'h1234;
    #1;
    chk("reset ready", bus.cache_ready, 0);
    chk("reset cache2mem", bus.cache2mem, 0);
    chk("reset count", bus.count, 0);
    chk("reset full", bus.full, 0);
    chk("reset w_ack", bus.w_ack, 0);
    exp_q.delete();
    exp_q.push_back(32'h1234);
    @(negedge clk);
    #3;
    rstn = 1'b1;
    #1;
    chk("post-reset ack", bus.w_ack, 4'b0100);
    @(negedge clk);
    bus.w_ena = '0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.cache_ready) pulses++;
    end
    chk("post-reset strobe count", pulses, 1);
    chk("post-reset word drained", exp_q.size(), 0);
    chk("post-reset count", bus.count, 0);

    // drain_en toggling with four words buffered.
    do_reset();
    fill(3, 4, 32'h71);
    mc      = 4;
    exp_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.w_ena    = '0;
      bus.drain_en = (k % 2 == 0);
      #1;
      chk($sformatf("toggle%0d ready", k), bus.cache_ready, exp_rdy);
      chk($sformatf("toggle%0d count", k), bus.count, mc);
      pop_m = bus.drain_en && (mc > 0);
      if (pop_m) mc--;
      exp_rdy = pop_m;
    end
    @(negedge clk);
    bus.drain_en = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("toggle words drained", exp_q.size(), 0);
    chk("toggle count", bus.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
